// File: rtl/iter_countdown_pkg.sv
// Shared types and constants for the iteration sequencer and its counters.
package iter_countdown_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } state_e;

endpackage

// File: rtl/counter_down_load.sv
// Loadable down counter; priority RST > LD > EN.
import iter_countdown_pkg::*;

module counter_down_load #(
    parameter int P = CNT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LD,
    input  logic [P-1:0] D,
    input  logic         EN,
    output logic [P-1:0] Y
);

    localparam logic [P-1:0] ONE = 1;

    logic [P-1:0] y_q;
    logic [P-1:0] y_d;

    always_comb begin
        y_d = y_q;
        if (LD) begin
            y_d = D;
        end else if (EN) begin
            y_d = y_q - ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: rtl/iter_countdown_ctrl.sv
// Down-counting iteration sequencer: START/count in, STEP_EN burst, one DONE.
import iter_countdown_pkg::*;

module iter_countdown_ctrl #(
    parameter int P = CNT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [P-1:0] LOAD_VAL,
    input  logic         HOLD,
    input  logic         ABORT,
    output logic         BUSY,
    output logic         STEP_EN,
    output logic [P-1:0] Y,
    output logic [P-1:0] ITER_IDX,
    output logic         DONE
);

    localparam logic [P-1:0] ONE = 1;

    state_e       state_q;
    state_e       state_d;
    logic [P-1:0] idx_q;
    logic [P-1:0] idx_d;
    logic         done_q;
    logic         accept;
    logic         step;
    logic         y_ld;
    logic [P-1:0] y_din;
    logic [P-1:0] y_w;

    assign accept = (state_q == ST_IDLE) && START && !ABORT;
    assign step   = (state_q == ST_RUN) && !HOLD && !ABORT;
    assign BUSY   = (state_q != ST_IDLE);

    // Abort clears the remaining count; a zero-length start loads zero.
    assign y_ld  = accept || (ABORT && BUSY);
    assign y_din = accept ? LOAD_VAL : '0;

    counter_down_load #(.P(P)) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .LD  (y_ld),
        .D   (y_din),
        .EN  (step),
        .Y   (y_w)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (LOAD_VAL != '0) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (!HOLD && (y_w == ONE)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (step) begin
            idx_d = idx_q + ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= (state_d == ST_FINISH);
        end
    end

    // An abort landing on the finish cycle still cancels the pulse.
    assign DONE     = done_q && !ABORT;
    assign STEP_EN  = step && !RST;
    assign Y        = y_w;
    assign ITER_IDX = idx_q;

endmodule

// File: tb/tb_iter_countdown_ctrl.sv
// Directed vector table plus hand-written corner sequences for iter_countdown_ctrl.
module tb_iter_countdown_ctrl;

    logic       CLK;
    logic       RST;
    logic       START;
    logic [4:0] LOAD_VAL;
    logic       HOLD;
    logic       ABORT;
    logic       BUSY;
    logic       STEP_EN;
    logic [4:0] Y;
    logic [4:0] ITER_IDX;
    logic       DONE;

    int total = 0;
    int bad   = 0;

    iter_countdown_ctrl #(.P(5)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .LOAD_VAL (LOAD_VAL),
        .HOLD     (HOLD),
        .ABORT    (ABORT),
        .BUSY     (BUSY),
        .STEP_EN  (STEP_EN),
        .Y        (Y),
        .ITER_IDX (ITER_IDX),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       st;
        logic [4:0] ld;
        logic       hd;
        logic       ab;
        logic       busy;
        logic       step;
        logic [4:0] y;
        logic [4:0] idx;
        logic       done;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic [4:0] ld, logic hd,
                                logic ab, logic busy, logic step,
                                logic [4:0] y, logic [4:0] idx,
                                logic done);
        vec_t v;
        v.st = st; v.ld = ld; v.hd = hd; v.ab = ab;
        v.busy = busy; v.step = step; v.y = y; v.idx = idx;
        v.done = done;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Advance to the next cycle and drive that cycle's inputs.
    task automatic cyc(logic st, logic [4:0] ld, logic hd, logic ab);
        @(posedge CLK);
        #1;
        START = st; LOAD_VAL = ld; HOLD = hd; ABORT = ab;
        #1;
    endtask

    task automatic chk_all(string tag, logic busy, logic step,
                           logic [4:0] y, logic [4:0] idx,
                           logic done);
        chk({tag, ".busy"}, int'(BUSY), int'(busy));
        chk({tag, ".step"}, int'(STEP_EN), int'(step));
        chk({tag, ".y"}, int'(Y), int'(y));
        chk({tag, ".idx"}, int'(ITER_IDX), int'(idx));
        chk({tag, ".done"}, int'(DONE), int'(done));
    endtask

    initial begin
        int steps;
        int dcyc;
        bit seen;

        RST = 1'b1; START = 1'b1; LOAD_VAL = 5'd9;
        HOLD = 1'b0; ABORT = 1'b0;

        // Reset held with START asserted: nothing may start.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #2;
            chk($sformatf("rst%0d.busy", i), int'(BUSY), 0);
            chk($sformatf("rst%0d.y", i), int'(Y), 0);
            chk($sformatf("rst%0d.done", i), int'(DONE), 0);
            chk($sformatf("rst%0d.step", i), int'(STEP_EN), 0);
        end
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        RST = 1'b0;
        chk_all("post_rst", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

        // Plain run of 4.
        tv.push_back(mk(1, 4, 0, 0,  0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 4, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 3, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 2, 2, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 1, 3, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0, 4, 1));
        tv.push_back(mk(0, 9, 0, 0,  0, 0, 0, 4, 0));
        // Run of 4 with HOLD in cycles 2-3.
        tv.push_back(mk(1, 4, 0, 0,  0, 0, 0, 4, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 4, 0, 0));
        tv.push_back(mk(0, 0, 1, 0,  1, 0, 3, 1, 0));
        tv.push_back(mk(0, 0, 1, 0,  1, 0, 3, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 3, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 2, 2, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 1, 3, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0, 4, 1));
        tv.push_back(mk(0, 0, 0, 0,  0, 0, 0, 4, 0));
        // Zero-length start goes straight to FINISH.
        tv.push_back(mk(1, 0, 0, 0,  0, 0, 0, 4, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0, 0));
        // START with ABORT in IDLE is dropped.
        tv.push_back(mk(1, 6, 0, 1,  0, 0, 0, 0, 0));
        tv.push_back(mk(0, 6, 0, 0,  0, 0, 0, 0, 0));
        // Back-to-back: START in FINISH ignored, next one taken.
        tv.push_back(mk(1, 2, 0, 0,  0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 2, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 1, 1, 0));
        tv.push_back(mk(1, 7, 0, 0,  1, 0, 0, 2, 1));
        tv.push_back(mk(1, 1, 0, 0,  0, 0, 0, 2, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 0, 0, 1, 1));
        tv.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0));
        // ABORT on the FINISH cycle suppresses DONE.
        tv.push_back(mk(1, 1, 0, 0,  0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 1, 0, 0));
        tv.push_back(mk(0, 0, 0, 1,  1, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0));
        // ABORT overrides HOLD in RUN.
        tv.push_back(mk(1, 5, 0, 0,  0, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  1, 1, 5, 0, 0));
        tv.push_back(mk(0, 0, 1, 1,  1, 0, 4, 1, 0));
        tv.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0));

        foreach (tv[i]) begin
            cyc(tv[i].st, tv[i].ld, tv[i].hd, tv[i].ab);
            chk_all($sformatf("tv%0d", i), tv[i].busy, tv[i].step,
                    tv[i].y, tv[i].idx, tv[i].done);
        end

        // LOAD_VAL=31, ABORT in cycle 10, restart in cycle 11.
        cyc(1'b1, 5'd31, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, 5'd0, 1'b0, 1'b0);
            chk($sformatf("ab_c%0d.y", k), int'(Y), 32 - k);
            chk($sformatf("ab_c%0d.step", k), int'(STEP_EN), 1);
        end
        cyc(1'b0, 5'd0, 1'b0, 1'b1);
        chk_all("ab_c10", 1'b1, 1'b0, 5'd22, 5'd9, 1'b0);
        cyc(1'b1, 5'd3, 1'b0, 1'b0);
        chk_all("ab_c11", 1'b0, 1'b0, 5'd0, 5'd9, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        chk_all("ab_c12", 1'b1, 1'b1, 5'd3, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        chk_all("ab_c15", 1'b1, 1'b0, 5'd0, 5'd3, 1'b1);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);

        // Full-scale run of 31 steps, bounded wait for DONE.
        cyc(1'b1, 5'd31, 1'b0, 1'b0);
        steps = 0;
        dcyc  = 0;
        seen  = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            cyc(1'b0, 5'd0, 1'b0, 1'b0);
            if (STEP_EN) steps++;
            if (DONE) begin
                seen = 1'b1;
                dcyc = k;
                chk("full.y", int'(Y), 0);
                chk("full.idx", int'(ITER_IDX), 31);
            end
        end
        chk("full.done_seen", int'(seen), 1);
        chk("full.steps", steps, 31);
        chk("full.done_cycle", dcyc, 32);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        chk("full.idle", int'(BUSY), 0);

        // RST mid-run at Y=7.
        cyc(1'b1, 5'd10, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        chk("mrst.y_before", int'(Y), 7);
        RST = 1'b1;
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        RST = 1'b0;
        chk_all("mrst.after", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 1'b0, 1'b0);
        chk_all("mrst.idle", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
